// File: rtl/threshold_alarm_filter_if.sv
// threshold_alarm_filter_if
//   Bundles the comparator flag inputs, control strobes and filtered alarm
//   outputs of threshold_alarm_filter.
//   master : drives enable/clear/greater/lesser/equal, observes the results
//   slave  : the filter itself
interface threshold_alarm_filter_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             clear;
  logic             greater;
  logic             lesser;
  logic             equal;
  logic             alarm;
  logic             alarm_rise;
  logic             alarm_fall;
  logic [CNT_W-1:0] event_count;
  logic [CNT_W-1:0] high_cycles;
  logic             err;

  modport master (
    output enable, clear, greater, lesser, equal,
    input  alarm, alarm_rise, alarm_fall, event_count, high_cycles, err
  );

  modport slave (
    input  enable, clear, greater, lesser, equal,
    output alarm, alarm_rise, alarm_fall, event_count, high_cycles, err
  );
endinterface

// File: rtl/threshold_alarm_filter.sv
// threshold_alarm_filter
//   Persistence filter with hysteresis on comparator greater/lesser/equal
//   flags. Alarm asserts after PERSIST consecutive GT samples and releases
//   after RELEASE consecutive LT samples. Keeps saturating event and
//   alarm-duration counters plus a sticky error for illegal flag codes.
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous active-high reset
//   bus  - slave side of threshold_alarm_filter_if (enable, clear, flags in;
//          alarm, alarm_rise, alarm_fall, event_count, high_cycles, err out)
//
// state   | meaning
// --------+-------------------------------------------------
// LOW     | alarm off, no GT run in progress
// PEND_HI | alarm off, counting consecutive GT samples
// HIGH    | alarm on, no LT run in progress
// PEND_LO | alarm on, counting consecutive LT samples
module threshold_alarm_filter #(
  parameter int PERSIST = 4,
  parameter int RELEASE = 4,
  parameter int CNT_W   = 16
) (
  input logic                     clk,
  input logic                     rst,
  threshold_alarm_filter_if.slave bus
);

  typedef enum logic [1:0] {LOW, PEND_HI, HIGH, PEND_LO} state_t;

  localparam logic [7:0] PERSIST_LAST = 8'(PERSIST - 1);
  localparam logic [7:0] RELEASE_LAST = 8'(RELEASE - 1);

  state_t           state, state_n;
  logic [7:0]       run, run_n;
  logic             alarm_q, rise_q, fall_q, err_q;
  logic             alarm_n;
  logic [CNT_W-1:0] event_q, high_q;
  logic             is_gt, is_lt, is_bad;
  logic             event_inc, high_inc;

  // BAD codes behave as EQ for the FSM; only err sees them.
  assign is_gt  = {bus.greater, bus.lesser, bus.equal} == 3'b100;
  assign is_lt  = {bus.greater, bus.lesser, bus.equal} == 3'b010;
  assign is_bad = !(is_gt || is_lt ||
                    ({bus.greater, bus.lesser, bus.equal} == 3'b001));

  always_comb begin
    state_n = state;
    run_n   = run;
    if (bus.enable) begin
      unique case (state)
        LOW: begin
          if (is_gt) begin
            if (PERSIST == 1) begin
              state_n = HIGH;
              run_n   = 8'd0;
            end else begin
              state_n = PEND_HI;
              run_n   = 8'd1;
            end
          end else if (is_lt) begin
            run_n = 8'd0;
          end
        end
        PEND_HI: begin
          if (is_gt) begin
            if (run == PERSIST_LAST) begin
              state_n = HIGH;
              run_n   = 8'd0;
            end else begin
              run_n = run + 8'd1;
            end
          end else if (is_lt) begin
            state_n = LOW;
            run_n   = 8'd0;
          end
        end
        HIGH: begin
          if (is_lt) begin
            if (RELEASE == 1) begin
              state_n = LOW;
              run_n   = 8'd0;
            end else begin
              state_n = PEND_LO;
              run_n   = 8'd1;
            end
          end else if (is_gt) begin
            run_n = 8'd0;
          end
        end
        PEND_LO: begin
          if (is_lt) begin
            if (run == RELEASE_LAST) begin
              state_n = LOW;
              run_n   = 8'd0;
            end else begin
              run_n = run + 8'd1;
            end
          end else if (is_gt) begin
            state_n = HIGH;
            run_n   = 8'd0;
          end
        end
        default: begin
          state_n = LOW;
          run_n   = 8'd0;
        end
      endcase
    end
  end

  // With enable=0 state_n equals state, so both edge pulses fall to 0.
  assign alarm_n   = (state_n == HIGH) || (state_n == PEND_LO);
  assign event_inc = (state_n == HIGH) && ((state == LOW) || (state == PEND_HI));
  assign high_inc  = bus.enable && alarm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOW;
      run     <= 8'd0;
      alarm_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      err_q   <= 1'b0;
      event_q <= '0;
      high_q  <= '0;
    end else begin
      state   <= state_n;
      run     <= run_n;
      alarm_q <= alarm_n;
      rise_q  <= alarm_n && !alarm_q;
      fall_q  <= !alarm_n && alarm_q;
      // clear takes priority: a same-cycle increment or error is dropped.
      if (bus.clear) begin
        err_q   <= 1'b0;
        event_q <= '0;
        high_q  <= '0;
      end else begin
        if (bus.enable && is_bad)
          err_q <= 1'b1;
        if (event_inc && (event_q != '1))
          event_q <= event_q + 1'b1;
        if (high_inc && (high_q != '1))
          high_q <= high_q + 1'b1;
      end
    end
  end

  assign bus.alarm       = alarm_q;
  assign bus.alarm_rise  = rise_q;
  assign bus.alarm_fall  = fall_q;
  assign bus.event_count = event_q;
  assign bus.high_cycles = high_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_threshold_alarm_filter.sv
module tb_threshold_alarm_filter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  threshold_alarm_filter_if #(.CNT_W(16)) bus  ();
  threshold_alarm_filter_if #(.CNT_W(4))  bus4 ();

  threshold_alarm_filter #(.PERSIST(4), .RELEASE(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  threshold_alarm_filter #(.PERSIST(1), .RELEASE(1), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic flags(input logic [2:0] f);
    {bus.greater, bus.lesser, bus.equal} = f;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [2:0] f);
    flags(f);
    cyc();
  endtask

  task automatic chk_main(input string tag, input logic a, input logic r, input logic fl,
                          input int ev, input int hc, input logic e);
    chk({tag, ".alarm"}, 32'(bus.alarm), 32'(a));
    chk({tag, ".rise"},  32'(bus.alarm_rise), 32'(r));
    chk({tag, ".fall"},  32'(bus.alarm_fall), 32'(fl));
    chk({tag, ".event"}, 32'(bus.event_count), 32'(ev));
    chk({tag, ".high"},  32'(bus.high_cycles), 32'(hc));
    chk({tag, ".err"},   32'(bus.err), 32'(e));
  endtask

  localparam logic [2:0] GT  = 3'b100;
  localparam logic [2:0] LT  = 3'b010;
  localparam logic [2:0] EQ  = 3'b001;
  localparam logic [2:0] Z   = 3'b000;
  localparam logic [2:0] MH  = 3'b110;
  localparam logic [2:0] MH2 = 3'b011;

  initial begin
    bus.enable = 1'b1; bus.clear = 1'b0; flags(GT);
    bus4.enable = 1'b0; bus4.clear = 1'b0;
    {bus4.greater, bus4.lesser, bus4.equal} = EQ;

    // reset dominates enable and clear
    rst = 1'b1; bus.clear = 1'b1;
    cyc(); cyc();
    chk_main("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0; bus.clear = 1'b0;

    // four GT samples to assert
    step(GT); step(GT); step(GT);
    chk_main("gt3", 0, 0, 0, 0, 0, 0);
    step(GT);
    chk_main("gt4", 1, 1, 0, 1, 0, 0);
    step(EQ);
    chk_main("gt4_next", 1, 0, 0, 1, 1, 0);

    // release with an EQ in the middle of the LT run
    step(LT); step(LT); step(EQ); step(LT);
    chk_main("lt3_eq", 1, 0, 0, 1, 5, 0);
    step(LT);
    chk_main("lt4", 0, 0, 1, 1, 6, 0);
    step(EQ);
    chk_main("lt4_next", 0, 0, 0, 1, 6, 0);

    // interrupted GT run never reaches PERSIST
    step(GT); step(GT); step(GT); step(LT); step(GT); step(GT); step(GT);
    chk_main("interrupted", 0, 0, 0, 1, 6, 0);
    step(GT);
    chk_main("resumed", 1, 1, 0, 2, 6, 0);

    // illegal codes set sticky err, state held (treated as EQ)
    step(Z);
    chk_main("bad000", 1, 0, 0, 2, 7, 1);
    step(MH);
    chk_main("bad110", 1, 0, 0, 2, 8, 1);
    step(EQ);
    chk_main("err_sticky", 1, 0, 0, 2, 9, 1);

    // clear wins over same-cycle increment and err set; alarm untouched
    bus.clear = 1'b1;
    step(MH2);
    bus.clear = 1'b0;
    chk_main("clear", 1, 0, 0, 0, 0, 0);
    step(EQ);
    chk_main("after_clear", 1, 0, 0, 0, 1, 0);

    // drop back to LOW
    step(LT); step(LT); step(LT); step(LT);
    chk_main("to_low", 0, 0, 1, 0, 5, 0);

    // enable=0 freezes a pending GT run
    step(GT); step(GT);
    bus.enable = 1'b0;
    for (int i = 0; i < 10; i++) step(GT);
    chk_main("frozen", 0, 0, 0, 0, 5, 0);
    bus.enable = 1'b1;
    step(GT);
    chk_main("resume3", 0, 0, 0, 0, 5, 0);
    step(GT);
    chk_main("resume4", 1, 1, 0, 1, 5, 0);
    // disabled cycle: pulse cleared, high_cycles held
    bus.enable = 1'b0;
    step(LT);
    chk_main("dis_pulse", 1, 0, 0, 1, 5, 0);
    bus.enable = 1'b1;

    // reset mid-PEND_HI discards the run
    step(LT); step(LT); step(LT); step(LT);
    chk_main("low_again", 0, 0, 1, 1, 9, 0);
    step(GT); step(GT); step(GT);
    rst = 1'b1;
    step(GT);
    rst = 1'b0;
    chk_main("rst_pend", 0, 0, 0, 0, 0, 0);
    step(GT);
    chk_main("post_rst1", 0, 0, 0, 0, 0, 0);
    step(GT); step(GT); step(GT);
    chk_main("post_rst4", 1, 1, 0, 1, 0, 0);

    // CNT_W=4, PERSIST=RELEASE=1: counters saturate at 15
    bus.enable = 1'b0;
    bus4.enable = 1'b1;
    for (int ep = 1; ep <= 20; ep++) begin
      {bus4.greater, bus4.lesser, bus4.equal} = GT;
      cyc();
      if (ep == 1) begin
        chk("sat.first_alarm", 32'(bus4.alarm), 32'd1);
        chk("sat.first_rise",  32'(bus4.alarm_rise), 32'd1);
        chk("sat.first_event", 32'(bus4.event_count), 32'd1);
      end
      if (ep == 15) chk("sat.event15", 32'(bus4.event_count), 32'd15);
      if (ep == 16) chk("sat.event16", 32'(bus4.event_count), 32'd15);
      {bus4.greater, bus4.lesser, bus4.equal} = LT;
      cyc();
      if (ep == 1) begin
        chk("sat.first_fall", 32'(bus4.alarm_fall), 32'd1);
        chk("sat.first_low",  32'(bus4.alarm), 32'd0);
      end
    end
    chk("sat.event20", 32'(bus4.event_count), 32'd15);
    chk("sat.high20",  32'(bus4.high_cycles), 32'd15);
    chk("sat.err",     32'(bus4.err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
